// File: rtl/level_fifo_pkg.sv
// Shared helpers for level_fifo: count width, wrapping pointer increment and
// the default entry layout carried through the RAM.
package level_fifo_pkg;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Wraps at depth-1 so non-power-of-2 depths use every entry.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

   typedef struct packed {
      logic        meta;
      logic [31:0] data;
   } entry_default_t;

endpackage

// File: rtl/level_fifo_ram.sv
// Storage array for level_fifo: one synchronous write port, one asynchronous
// read port, no reset on the contents.
module level_fifo_ram
   import level_fifo_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter type         ENTRY_T = entry_default_t,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_addr,
   input  ENTRY_T           wr_entry,
   input  logic [PTR_W-1:0] rd_addr,
   output ENTRY_T           rd_entry
);

   ENTRY_T mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_entry;

   assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/level_fifo.sv
// Level-based synchronous FIFO with valid/ready on both sides, occupancy count
// and almost flags. Optional sticky overflow/underflow ports: LEVEL_FIFO_ERR_EN.
module level_fifo
   import level_fifo_pkg::*;
#(
   parameter int unsigned BIT_WIDTH     = 32,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned READ_CYCLES   = 0,
   parameter int unsigned AFULL_THRESH  = DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = 1,
   parameter type         METADATA_TYPE = logic,
   localparam int unsigned CNT_W        = cnt_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_data,
   input  METADATA_TYPE         in_metadata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out_data,
   output METADATA_TYPE         out_metadata,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty
`ifdef LEVEL_FIFO_ERR_EN
   ,
   output logic                 overflow,
   output logic                 underflow
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      METADATA_TYPE         meta;
      logic [BIT_WIDTH-1:0] data;
   } entry_t;

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   entry_t           wr_entry, rd_entry;
   logic             push, pop, ram_rd;

   assign in_ready      = (count != CNT_W'(DEPTH));
   assign push          = in_valid & in_ready;
   assign pop           = out_valid & out_ready;
   assign wr_entry.meta = in_metadata;
   assign wr_entry.data = in_data;

   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_W'(AFULL_THRESH));
   assign almost_empty = (count <= CNT_W'(AEMPTY_THRESH));

   // count covers RAM plus any output register, so capacity is exactly DEPTH.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
         if (ram_rd) rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end

   level_fifo_ram #(
      .DEPTH   (DEPTH),
      .ENTRY_T (entry_t)
   ) u_ram (
      .clk      (clk),
      .we       (push),
      .wr_addr  (wr_ptr),
      .wr_entry (wr_entry),
      .rd_addr  (rd_ptr),
      .rd_entry (rd_entry)
   );

   if (READ_CYCLES == 0) begin : g_showahead
      assign ram_rd       = pop;
      assign out_valid    = !empty;
      // Gate the unreset RAM so idle outputs read as zero.
      assign out_data     = out_valid ? rd_entry.data : '0;
      assign out_metadata = out_valid ? rd_entry.meta : '0;
   end else begin : g_outreg
      logic             reg_vld;
      entry_t           reg_entry;
      logic [CNT_W-1:0] ram_cnt;

      assign ram_cnt = count - CNT_W'(reg_vld);
      // Refill when the register is free or leaving this cycle.
      assign ram_rd  = (!reg_vld || pop) && (ram_cnt != '0);

      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            reg_vld   <= 1'b0;
            reg_entry <= '0;
         end else if (ram_rd) begin
            reg_vld   <= 1'b1;
            reg_entry <= rd_entry;
         end else if (pop) begin
            reg_vld   <= 1'b0;
         end

      assign out_valid    = reg_vld;
      assign out_data     = reg_entry.data;
      assign out_metadata = reg_entry.meta;
   end

`ifdef LEVEL_FIFO_ERR_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (in_valid && !in_ready)  overflow  <= 1'b1;
         if (out_ready && !out_valid) underflow <= 1'b1;
      end
`endif

endmodule

// File: tb/tb_level_fifo.sv
// Bench for level_fifo: show-ahead and registered-output instances (DEPTH=5)
// driven together and compared against queue-based reference models.
module tb_level_fifo;

   typedef logic [1:0] meta_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = '0;
   meta_t      in_meta = '0;

   logic [1:0] rdy, vld, fl, em, af, ae, ovf, unf;
   logic [7:0] dat [2];
   meta_t      mt  [2];
   logic [2:0] cnt [2];

   int nchk = 0, nerr = 0;

   always #5 clk = ~clk;

   level_fifo #(.BIT_WIDTH(8), .DEPTH(5), .READ_CYCLES(0), .AFULL_THRESH(4),
                .AEMPTY_THRESH(1), .METADATA_TYPE(meta_t)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data), .in_metadata(in_meta), .out_valid(vld[0]),
      .out_ready(out_ready), .out_data(dat[0]), .out_metadata(mt[0]),
      .count(cnt[0]), .full(fl[0]), .empty(em[0]), .almost_full(af[0]),
      .almost_empty(ae[0])
`ifdef LEVEL_FIFO_ERR_EN
      , .overflow(ovf[0]), .underflow(unf[0])
`endif
   );

   level_fifo #(.BIT_WIDTH(8), .DEPTH(5), .READ_CYCLES(1), .AFULL_THRESH(4),
                .AEMPTY_THRESH(1), .METADATA_TYPE(meta_t)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data), .in_metadata(in_meta), .out_valid(vld[1]),
      .out_ready(out_ready), .out_data(dat[1]), .out_metadata(mt[1]),
      .count(cnt[1]), .full(fl[1]), .empty(em[1]), .almost_full(af[1]),
      .almost_empty(ae[1])
`ifdef LEVEL_FIFO_ERR_EN
      , .overflow(ovf[1]), .underflow(unf[1])
`endif
   );

`ifndef LEVEL_FIFO_ERR_EN
   assign ovf = '0;
   assign unf = '0;
`endif

   // Reference state: whole-FIFO queue for show-ahead; RAM queue plus a
   // head slot for the registered-output instance.
   logic [9:0] q0[$];
   logic [9:0] r1[$];
   bit         rv1;
   logic [9:0] rd1;
   bit   [1:0] mov, mun;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      int c;
      bit v;
      logic [9:0] h;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            c = q0.size();
            v = (c > 0);
            h = v ? q0[0] : 10'h0;
         end else begin
            c = r1.size() + (rv1 ? 1 : 0);
            v = rv1;
            h = rd1;
         end
         chk($sformatf("count%0d", k), 32'(cnt[k]), 32'(c));
         chk($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(c < 5));
         chk($sformatf("out_valid%0d", k), 32'(vld[k]), 32'(v));
         chk($sformatf("full%0d", k), 32'(fl[k]), 32'(c == 5));
         chk($sformatf("empty%0d", k), 32'(em[k]), 32'(c == 0));
         chk($sformatf("afull%0d", k), 32'(af[k]), 32'(c >= 4));
         chk($sformatf("aempty%0d", k), 32'(ae[k]), 32'(c <= 1));
         if (v) begin
            chk($sformatf("data%0d", k), 32'(dat[k]), 32'(h[7:0]));
            chk($sformatf("meta%0d", k), 32'(mt[k]), 32'(h[9:8]));
         end
`ifdef LEVEL_FIFO_ERR_EN
         chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(mov[k]));
         chk($sformatf("underflow%0d", k), 32'(unf[k]), 32'(mun[k]));
`endif
      end
   endtask

   task automatic model_step();
      int c0, c1;
      bit p1, o1;
      c0 = q0.size();
      if (in_valid && c0 >= 5) mov[0] = 1'b1;
      if (out_ready && c0 == 0) mun[0] = 1'b1;
      if (out_ready && c0 > 0) void'(q0.pop_front());
      if (in_valid && c0 < 5) q0.push_back({in_meta, in_data});

      c1 = r1.size() + (rv1 ? 1 : 0);
      p1 = in_valid && c1 < 5;
      o1 = out_ready && rv1;
      if (in_valid && !p1) mov[1] = 1'b1;
      if (out_ready && !rv1) mun[1] = 1'b1;
      if ((!rv1 || o1) && r1.size() > 0) begin
         rd1 = r1.pop_front();
         rv1 = 1'b1;
      end else if (o1) begin
         rv1 = 1'b0;
      end
      if (p1) r1.push_back({in_meta, in_data});
   endtask

   // One clock: drive, check before the edge, advance model, land at edge+1.
   task automatic cyc(input logic iv, input logic [7:0] d, input meta_t m, input logic ordy);
      in_valid = iv; in_data = d; in_meta = m; out_ready = ordy;
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      q0.delete(); r1.delete(); rv1 = 1'b0; rd1 = '0; mov = '0; mun = '0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_in_ready%0d", k), 32'(rdy[k]), 32'd1);
         chk($sformatf("rst_out_valid%0d", k), 32'(vld[k]), 32'd0);
         chk($sformatf("rst_count%0d", k), 32'(cnt[k]), 32'd0);
         chk($sformatf("rst_empty%0d", k), 32'(em[k]), 32'd1);
         chk($sformatf("rst_aempty%0d", k), 32'(ae[k]), 32'd1);
         chk($sformatf("rst_full%0d", k), 32'(fl[k]), 32'd0);
         chk($sformatf("rst_afull%0d", k), 32'(af[k]), 32'd0);
         chk($sformatf("rst_data%0d", k), 32'(dat[k]), 32'd0);
         chk($sformatf("rst_meta%0d", k), 32'(mt[k]), 32'd0);
         chk($sformatf("rst_ovf%0d", k), 32'(ovf[k]), 32'd0);
         chk($sformatf("rst_unf%0d", k), 32'(unf[k]), 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] d;
      @(posedge clk);
      #1;
      do_reset();

      // Fill past capacity: 0x15 must be refused.
      for (int i = 0; i < 6; i++) begin
         d = 8'h10 + 8'(i);
         cyc(1'b1, d, d[1:0], 1'b0);
      end
      chk("fill_full0", 32'(fl[0]), 32'd1);
      chk("fill_count1", 32'(cnt[1]), 32'd5);
      // Drain, with extra pops on empty.
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1);
      chk("drain_empty0", 32'(em[0]), 32'd1);
      chk("drain_empty1", 32'(em[1]), 32'd1);

      // Wrap: hold the level at 2 while streaming 0x20..0x2B.
      for (int i = 0; i < 12; i++) begin
         d = 8'h20 + 8'(i);
         cyc(1'b1, d, d[1:0], i >= 2);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1);

      // Full plus pop: pop happens, push refused; accepted next cycle.
      for (int i = 0; i < 5; i++) begin
         d = 8'h30 + 8'(i);
         cyc(1'b1, d, d[1:0], 1'b0);
      end
      cyc(1'b1, 8'h35, 2'd1, 1'b1);
      chk("fullpop_count0", 32'(cnt[0]), 32'd4);
      cyc(1'b1, 8'h35, 2'd1, 1'b0);
      chk("fullpop_refill0", 32'(cnt[0]), 32'd5);
      for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1);

      // Registered-output latency and back-pressure hold.
      cyc(1'b1, 8'hAA, 2'd2, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 2'd0, 1'b0);
      chk("lat_valid1", 32'(vld[1]), 32'd1);
      chk("lat_data1", 32'(dat[1]), 32'hAA);
      cyc(1'b0, 8'h00, 2'd0, 1'b1);

      // Random traffic with a reset dropped in mid-burst.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         cyc($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
             $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/level_fifo.md
# level_fifo

Parametrised synchronous FIFO; successor to the basic pointer-pair FIFO. Adds arbitrary (non-power-of-2) depth using every entry, an explicit occupancy count, programmable almost-full/almost-empty flags, valid/ready handshakes on both sides, and a registered-output mode with correct back-pressure. It sits between stream producers and consumers in the solver pipelines, wherever a stage needs level-based flow control rather than a bare full/empty signal.

## Interface
- BIT_WIDTH, 32: payload width.
- DEPTH, 16: capacity in entries; any integer ≥ 2.
- READ_CYCLES, 0: 0 = show-ahead (combinational read); 1 = registered output stage.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ this value; range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when count ≤ this value; range 0..DEPTH-1.
- METADATA_TYPE, logic: sideband type; travels with each payload.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  FIFO accepts; push = in_valid & in_ready.
- in_data  in  BIT_WIDTH  payload.
- in_metadata  in  METADATA_TYPE  sideband.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes; pop = out_valid & out_ready.
- out_data  out  BIT_WIDTH  head payload.
- out_metadata  out  METADATA_TYPE  head sideband.
- count  out  $clog2(DEPTH+1)  entries held (RAM plus output register).
- full, empty, almost_full, almost_empty  out  1  each: level flags derived from count.

## Operation
- Pointers wr_ptr and rd_ptr have width $clog2(DEPTH) and wrap from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
- count is a register: +1 on push only, -1 on pop only, unchanged on push and pop together or neither.
- in_ready = (count != DEPTH). When full there is no pass-through: a simultaneous pop does not enable a push that cycle.
- full = (count == DEPTH); empty = (count == 0); flags are combinational from count only.
- A pop while out_valid=0 has no effect. A push while in_ready=0 is dropped; the producer holds the word.
- READ_CYCLES=0: out_valid = !empty; out_data/out_metadata = mem[rd_ptr].
- READ_CYCLES=1: an output register holds the head word. It loads from RAM when it is empty, or is popped this cycle, and the RAM is non-empty. out_valid is the register's occupancy bit. count includes the register, so total capacity stays DEPTH.
- Ordering is strictly FIFO across wrap and across the RAM-to-register boundary.
- Reset (rst_n=0, any time, including mid-transfer): wr_ptr, rd_ptr and count go to 0. Output register clears. Outputs take:
  - in_ready=1, out_valid=0, out_data=0, out_metadata=0, count=0.
  - empty=1, full=0.
  - almost_empty=1; almost_full=0 (AFULL_THRESH ≥ 1).
  - RAM contents are not reset.

## Timing
- Push in cycle N: count updates at edge N+1.
- READ_CYCLES=0: word visible on out_* after edge N+1 (one-cycle latency when the FIFO was empty).
- READ_CYCLES=1: latency is two cycles; out_valid rises after edge N+2.
- Steady state sustains one push and one pop per cycle in both modes.
- Reset deassertion is synchronised externally; the first push is accepted on the first posedge with rst_n=1.

## Configuration
- LEVEL_FIFO_ERR_EN defined: adds ports overflow and underflow (outputs, 1 bit each), sticky, cleared only by reset.
  - overflow sets at the edge after in_valid & !in_ready.
  - underflow sets at the edge after out_ready & !out_valid.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package level_fifo_pkg: function for count width (clog2(DEPTH+1)); pointer-increment-with-wrap function; packed entry struct template (data plus metadata) used by the RAM.
- Sub-module level_fifo_ram: simple dual-port array with one write port and one asynchronous read port. The registered output stage lives in level_fifo, not in the RAM.

## Test plan
- Reset: assert rst_n=0 mid-cycle → immediately in_ready=1, out_valid=0, count=0, empty=1, almost_empty=1, full=0.
- Non-power-of-2 fill (DEPTH=5, AFULL_THRESH=4):
  - Push 0x10..0x14 → almost_full at count=4, full and in_ready=0 at count=5; a 6th push (0x15) is dropped.
  - Drain → 0x10..0x14 in order, empty at end.
- Wrap: DEPTH=5, 12 interleaved push/pop pairs of 0x20..0x2B with count kept at 2 → output sequence exact; count constant at 2.
- Full plus pop: at count=5, assert in_valid and out_ready together → pop occurs, push refused, count=4. Next cycle the push is accepted and count=5.
- READ_CYCLES=1 latency/back-pressure:
  - Push 0xAA at cycle 0 into empty FIFO → out_valid=1 with 0xAA at cycle 2.
  - Hold out_ready=0 for 3 cycles → data stable.
- LEVEL_FIFO_ERR_EN:
  - Push when full → overflow=1 and stays 1 until reset.
  - Pop when empty → underflow=1.
  - Reset mid-burst → both flags return to 0, count=0.
